// File: rtl/medidor_pwm.sv
// PWM meter: synchronizes an external PWM input and measures the high time and
// period of each complete cycle, in clk cycles, with a timeout for lost signal.
module medidor_pwm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pwm_in,
  output logic [9:0] ancho_alto,
  output logic [9:0] periodo,
  output logic       dato_valido,
  output logic       sin_senal
);

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ESPERA_SUBIDA,
    ALTO,
    BAJO
  } estado_t;

  estado_t    estado;
  logic       s1, s2, s_prev;
  logic [9:0] cnt_per;
  logic [9:0] cnt_alto;

  logic subida, bajada;
  logic saturado, cierre, timeout;

  assign subida   = s2 & ~s_prev;
  assign bajada   = ~s2 & s_prev;
  assign saturado = (cnt_per == CNT_MAX);
  // A period closing exactly at 1023 wins over the timeout.
  assign cierre   = (estado == BAJO) && subida;
  assign timeout  = (estado != ESPERA_SUBIDA) && saturado && !cierre;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= pwm_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado      <= ESPERA_SUBIDA;
      cnt_per     <= '0;
      cnt_alto    <= '0;
      ancho_alto  <= '0;
      periodo     <= '0;
      dato_valido <= 1'b0;
      sin_senal   <= 1'b1;
    end else begin
      // NOTE: the strobe defaults low every cycle, so it can only ever last one
      // cycle and no path leaves it holding a stale value.
      dato_valido <= 1'b0;

      if (timeout) begin
        periodo     <= '0;
        ancho_alto  <= s2 ? CNT_MAX : 10'd0;
        sin_senal   <= 1'b1;
        dato_valido <= 1'b1;
        cnt_per     <= '0;
        cnt_alto    <= '0;
        estado      <= ESPERA_SUBIDA;
      end else begin
        case (estado)
          ESPERA_SUBIDA: begin
            if (subida) begin
              cnt_per  <= 10'd1;
              cnt_alto <= 10'd1;
              estado   <= ALTO;
            end else begin
              cnt_per  <= '0;
              cnt_alto <= '0;
            end
          end

          ALTO: begin
            // Not saturated here, so the increment cannot wrap.
            cnt_per <= cnt_per + 10'd1;
            if (bajada) begin
              estado <= BAJO;
            end else begin
              cnt_alto <= cnt_alto + 10'd1;
            end
          end

          BAJO: begin
            if (subida) begin
              periodo     <= cnt_per;
              ancho_alto  <= cnt_alto;
              sin_senal   <= 1'b0;
              dato_valido <= 1'b1;
              cnt_per     <= 10'd1;
              cnt_alto    <= 10'd1;
              estado      <= ALTO;
            end else begin
              cnt_per <= cnt_per + 10'd1;
            end
          end

          default: begin
            cnt_per  <= '0;
            cnt_alto <= '0;
            estado   <= ESPERA_SUBIDA;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_medidor_pwm.sv
// Directed bench for medidor_pwm: stimulus pushes expected measurements into a
// queue, and an independent monitor pops and compares them on every strobe.
module tb_medidor_pwm;

  logic       clk;
  logic       reset_n;
  logic       pwm_in;
  logic [9:0] ancho_alto;
  logic [9:0] periodo;
  logic       dato_valido;
  logic       sin_senal;

  typedef struct {
    int ancho;
    int per;
    int sin;
  } esperado_t;

  esperado_t cola[$];
  int checks   = 0;
  int failures = 0;

  medidor_pwm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwm_in      (pwm_in),
    .ancho_alto  (ancho_alto),
    .periodo     (periodo),
    .dato_valido (dato_valido),
    .sin_senal   (sin_senal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push(input int ancho, input int per, input int sin);
    esperado_t e;
    e.ancho = ancho;
    e.per   = per;
    e.sin   = sin;
    cola.push_back(e);
  endtask

  // Holds pwm_in at a level for n clk edges; called on a falling edge.
  task automatic hold(input logic level, input int n);
    pwm_in = level;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  initial begin : monitor
    logic prev_dv;
    esperado_t e;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (dato_valido) begin
        if (prev_dv) check("dv_consecutive", 1, 0);
        if (cola.size() == 0) begin
          check("unexpected_strobe", 0, 1);
        end else begin
          e = cola.pop_front();
          check("ancho_alto", int'(ancho_alto), e.ancho);
          check("periodo", int'(periodo), e.per);
          check("sin_senal", int'(sin_senal), e.sin);
        end
      end
      prev_dv = dato_valido;
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ancho", int'(ancho_alto), 0);
    check("rst_periodo", int'(periodo), 0);
    check("rst_sin", int'(sin_senal), 1);
    check("rst_dv", int'(dato_valido), 0);
    reset_n = 1'b1;
    hold(1'b0, 5);

    // Steady H=30/L=70: first rise only arms the measurement.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(30, 100, 0);
      hold(1'b1, 30);
      if (i == 0) check("sin_before_first", int'(sin_senal), 1);
      hold(1'b0, 70);
    end

    // H=1/L=1022: period of exactly 1023 is valid.
    push(30, 100, 0);
    hold(1'b1, 1);
    hold(1'b0, 1022);

    // Low for 1100 after one complete period -> timeout with ancho 0.
    push(1, 1023, 0);
    hold(1'b1, 10);
    push(0, 0, 1);
    hold(1'b0, 1100);
    check("sin_after_low_to", int'(sin_senal), 1);

    // High for 1100 -> timeout with ancho 1023, then resume after two rises.
    push(1023, 0, 1);
    hold(1'b1, 1100);
    hold(1'b0, 20);
    hold(1'b1, 15);
    hold(1'b0, 25);
    push(15, 40, 0);
    hold(1'b1, 15);
    hold(1'b0, 25);

    // H=20/L=20 with a one-cycle reset in the low phase.
    push(15, 40, 0);
    hold(1'b1, 20);
    hold(1'b0, 5);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ancho", int'(ancho_alto), 0);
    check("midrst_periodo", int'(periodo), 0);
    check("midrst_sin", int'(sin_senal), 1);
    check("midrst_dv", int'(dato_valido), 0);
    reset_n = 1'b1;
    hold(1'b0, 14);
    hold(1'b1, 20);
    hold(1'b0, 20);
    check("sin_until_2nd_rise", int'(sin_senal), 1);
    push(20, 40, 0);
    hold(1'b1, 20);
    hold(1'b0, 20);

    // Latency: rise just before edge k, strobe visible after edge k+2.
    push(20, 40, 0);
    pwm_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_dv_k1", int'(dato_valido), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_dv_k2", int'(dato_valido), 1);
    hold(1'b1, 17);
    hold(1'b0, 20);
    push(20, 40, 0);
    hold(1'b1, 5);
    hold(1'b0, 10);

    check("queue_drained", cola.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/medidor_pwm.md
MEDIDOR_PWM -- requirements
Module: medidor_pwm

Interface
REQ-001 The block SHALL have these ports, one clock domain; clock and reset come first:
  clk          input   1   system clock; all state updates on its rising edge
  reset_n      input   1   synchronous reset, active-low
  pwm_in       input   1   external PWM signal, asynchronous to clk
  ancho_alto   output  10  measured high time of the last complete period, in clk cycles
  periodo      output  10  measured period of the last complete period, in clk cycles
  dato_valido  output  1   one-cycle strobe when ancho_alto/periodo/sin_senal are updated
  sin_senal    output  1   1 = no valid measurement (after reset or after timeout)
REQ-002 Reset SHALL be synchronous and active-low: sampled only on a rising edge of clk with reset_n=0.

Function
REQ-003 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2), and s2 SHALL be registered once more into s_prev.
REQ-004 Edge detection SHALL be subida = s2 & ~s_prev and bajada = ~s2 & s_prev.
REQ-005 The controller SHALL have three states: ESPERA_SUBIDA (reset state), ALTO, BAJO.
REQ-006 In ESPERA_SUBIDA:
  - cnt_per and cnt_alto held at 0; bajada ignored.
  - subida sets cnt_per=1 and cnt_alto=1, moves to ALTO, and produces no strobe.
REQ-007 In ALTO:
  - cnt_per and cnt_alto increment by 1 each cycle.
  - bajada moves to BAJO, freezes cnt_alto (the bajada cycle is not counted as high) and still increments cnt_per.
REQ-008 In BAJO, without subida, cnt_per SHALL increment by 1 and cnt_alto SHALL hold.
REQ-009 In BAJO with subida, the block SHALL, in the same cycle:
  - load periodo<=cnt_per and ancho_alto<=cnt_alto;
  - set dato_valido=1 and sin_senal<=0;
  - restart cnt_per=1 and cnt_alto=1;
  - stay in the measuring loop by moving to ALTO.
REQ-010 For an input with H high and L low cycles (H,L>=1, H+L<=1023) in steady state, the outputs SHALL be ancho_alto=H and periodo=H+L.
REQ-011 Latency: dato_valido SHALL be high after the 3rd rising clk edge counted from the first edge at which pwm_in is sampled high following a low phase.
REQ-012 Counters SHALL be 10-bit unsigned and SHALL never wrap past 1023.
REQ-013 Timeout condition: state is ALTO or BAJO, cnt_per==1023, and there is no (BAJO and subida) in that cycle. On timeout the block SHALL, in the same cycle:
  - set periodo<=0 and sin_senal<=1;
  - set ancho_alto<=1023 if s2=1, otherwise ancho_alto<=0;
  - pulse dato_valido=1;
  - clear both counters and return to ESPERA_SUBIDA.
REQ-014 Boundary: a period of exactly 1023 cycles SHALL be measured as valid (periodo=1023); a period of 1024 or more cycles SHALL produce the timeout of REQ-013.
REQ-015 dato_valido SHALL be high for exactly one cycle per update, and never for two consecutive cycles.
REQ-016 ancho_alto, periodo and sin_senal SHALL hold their values between strobes.
REQ-017 A glitch shorter than one clk period that is not captured by s1 SHALL have no effect. A captured one-cycle pulse SHALL be measured as H=1.

Reset
REQ-018 While reset_n=0 at a clk edge, the block SHALL set:
  - s1=s2=s_prev=0 and state=ESPERA_SUBIDA;
  - cnt_per=cnt_alto=0;
  - ancho_alto=0, periodo=0, dato_valido=0, sin_senal=1.
REQ-019 Reset asserted mid-measurement SHALL discard the partial measurement, with no strobe on the reset cycle or the cycle after it.
REQ-020 After reset release, the first complete period SHALL be reported only at the second synchronized rising edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - pwm_in steady H=30/L=70 -> from the 2nd rising edge on, each period gives ancho_alto=30, periodo=100, sin_senal=0, one dato_valido per period.
  - H=1/L=1022 (period 1023) -> ancho_alto=1, periodo=1023, no timeout.
  - pwm_in held low for 1100 cycles after one complete period -> one strobe with periodo=0, ancho_alto=0, sin_senal=1, then silence.
  - pwm_in held high for 1100 cycles -> one strobe with periodo=0, ancho_alto=1023, sin_senal=1. After pwm_in drops and then rises twice, a valid measurement resumes.
  - reset_n=0 for 1 cycle during the low phase of H=20/L=20 -> all outputs return to reset values, the next strobe comes at the 2nd rising edge after release with 20/40, and sin_senal stays 1 until then.
  - latency check: pwm_in goes 0->1 just before edge k -> dato_valido=1 in the cycle after edge k+2.
